// File: rtl/reg_file_pkg.sv
// Shared constants for the register file and its users (decoder, benches).
// Optional build macro: REGFILE_BYPASS_EN (write-first read bypass).
package reg_file_pkg;

    // Default geometry: 32 registers of 32 bits
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    // Register 0 is hardwired to zero
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Named register indices shared with the decoder
    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_RA = 5'd31;

    // True when an index addresses the hardwired-zero register
    function automatic logic is_zero_idx(input logic [4:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: two read ports and one write port.
// The datapath side (decoder / writeback) is the master, the register file the slave.
interface reg_file_if #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
);

    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    modport master (
        output ra1,
        output ra2,
        input  rd1,
        input  rd2,
        output we,
        output wa,
        output wd
    );

    modport slave (
        input  ra1,
        input  ra2,
        output rd1,
        output rd2,
        input  we,
        input  wa,
        input  wd
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: forces index 0 and reset to zero and, when
// REGFILE_BYPASS_EN is defined, forwards same-cycle write data (write-first).
module reg_file_read_port #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clear,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
`endif
    output logic [DATA_W-1:0] rd
);
    import reg_file_pkg::*;

    logic ra_is_zero;

    assign ra_is_zero = (ra == ADDR_W'(REG_ZERO));

    // Select zero, forwarded write data or stored contents
    always_comb begin
        rd = '0;
        if (!clear && !ra_is_zero) begin
            rd = stored;
`ifdef REGFILE_BYPASS_EN
            if (we && (wa == ra)) begin
                rd = wd;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: register 0 reads as zero, two
// combinational read ports, one clocked write port, asynchronous active-high
// reset clearing every register.
// Optional build macro: REGFILE_BYPASS_EN (write-first read bypass).
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input logic        clk,
    input logic        rst,
    reg_file_if.slave  bus
);
    import reg_file_pkg::*;

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              write_ok;

    // Writes to index 0 are dropped so register 0 never leaves zero
    assign write_ok = bus.we && (bus.wa != ADDR_W'(REG_ZERO));

    // Register storage: reset clears all entries, otherwise clocked write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    assign stored1 = regs[bus.ra1];
    assign stored2 = regs[bus.ra2];

    reg_file_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_read_port1 (
        .clear (rst),
        .ra    (bus.ra1),
        .stored(stored1),
`ifdef REGFILE_BYPASS_EN
        .we    (bus.we),
        .wa    (bus.wa),
        .wd    (bus.wd),
`endif
        .rd    (bus.rd1)
    );

    reg_file_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_read_port2 (
        .clear (rst),
        .ra    (bus.ra2),
        .stored(stored2),
`ifdef REGFILE_BYPASS_EN
        .we    (bus.we),
        .wa    (bus.wa),
        .wd    (bus.wd),
`endif
        .rd    (bus.rd2)
    );

endmodule
